// File: rtl/rtc_pscr_div_pkg.sv
// Shared types and defaults for the RTC prescaler.
package rtc_pscr_div_pkg;

    // Prescaler control states
    typedef enum logic [1:0] {
        RUN  = 2'd0,   // counting, divisor load may be accepted
        WAIT = 2'd1,   // divisor accepted, finishing the old period
        LOAD = 2'd2    // one-cycle swap of the pending divisor
    } pscr_state_e;

    // Divisor active out of reset (0 and 1 both tick every cycle)
    localparam int unsigned DIV_RST_DEF   = 1;
    localparam int unsigned DIV_WIDTH_DEF = 32;

endpackage

// File: rtl/rtc_pscr_div_if.sv
// Divisor load handshake between the CDC destination side and the prescaler.
interface rtc_pscr_div_if #(
    parameter int DIV_WIDTH = 32
);
    logic [DIV_WIDTH-1:0] div_i;        // requested divisor N
    logic                 div_valid_i;  // single-cycle valid pulse
    logic                 div_ready_o;  // prescaler can take a new divisor

    modport master (output div_i, output div_valid_i, input  div_ready_o);
    modport slave  (input  div_i, input  div_valid_i, output div_ready_o);
endinterface

// File: rtl/rtc_pscr_div_dffer.sv
// Register primitive: async active-low reset to RST_VAL, load when en_i.
module rtc_pscr_div_dffer #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // State holding register with enable
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  q_o <= RST_VAL;
        else if (en_i) q_o <= d_i;
    end

endmodule

// File: rtl/rtc_pscr_div.sv
// RTC prescaler: divides clk_i by a runtime-loaded divisor, emits one-cycle
// tick strobes and a decoded divided-clock level. New divisors arrive over a
// valid/ready handshake and are swapped in during a one-cycle LOAD state.
module rtc_pscr_div
    import rtc_pscr_div_pkg::*;
#(
    parameter int          DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int unsigned DIV_RST   = DIV_RST_DEF,
    parameter bit          ALIGN     = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    rtc_pscr_div_if.slave   div_if,
    output logic            div_done_o,
    output logic            clk_trg_o,
    output logic            clk_o
);

    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_RV  = DIV_WIDTH'(DIV_RST);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] pend_q;
    logic [DIV_WIDTH-1:0] lim;
    logic [1:0]           state_raw;
    pscr_state_e          state_q, state_d;
    logic                 tick_hit;
    logic                 hs;
    logic                 active;   // counter drives the outputs (RUN or WAIT)

    assign state_q = pscr_state_e'(state_raw);

    // Divisors 0 and 1 both collapse to a one-cycle period
    assign lim      = (div_q <= ONE) ? '0 : div_q - ONE;
    assign tick_hit = (cnt_q == lim);

    // Accept only in RUN; a valid seen elsewhere is dropped
    assign hs = div_if.div_valid_i && (state_q == RUN);

    // Counter wraps at lim and restarts the phase on every divisor swap
    assign cnt_d = ((state_q == LOAD) || tick_hit) ? '0 : cnt_q + ONE;

    rtc_pscr_div_dffer #(.W(DIV_WIDTH), .RST_VAL('0)) u_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (1'b1),
        .d_i     (cnt_d),
        .q_o     (cnt_q)
    );

    rtc_pscr_div_dffer #(.W(DIV_WIDTH), .RST_VAL('0)) u_pend (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (hs),
        .d_i     (div_if.div_i),
        .q_o     (pend_q)
    );

    rtc_pscr_div_dffer #(.W(DIV_WIDTH), .RST_VAL(DIV_RV)) u_div (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q == LOAD),
        .d_i     (pend_q),
        .q_o     (div_q)
    );

    rtc_pscr_div_dffer #(.W(2), .RST_VAL(2'(RUN))) u_state (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (1'b1),
        .d_i     (2'(state_d)),
        .q_o     (state_raw)
    );

    // Next-state and handshake/status outputs
    always_comb begin
        state_d            = state_q;
        div_if.div_ready_o = 1'b0;
        div_done_o         = 1'b1;
        active             = 1'b0;
        case (state_q)
            RUN: begin
                div_if.div_ready_o = 1'b1;
                active             = 1'b1;
                // With ALIGN, a handshake on a tick cycle already sits on the
                // period boundary, so WAIT is skipped
                if (hs) state_d = (!ALIGN || tick_hit) ? LOAD : WAIT;
            end
            WAIT: begin
                // Old period keeps running and still ticks at its end
                active = 1'b1;
                if (tick_hit) state_d = LOAD;
            end
            LOAD: begin
                div_done_o = 1'b0;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Strobes are forced low while reset is held so they clear asynchronously
    assign clk_trg_o = rst_n_i && active && tick_hit;
    assign clk_o     = rst_n_i && active && (div_q > ONE) && (cnt_q < (div_q >> 1));

endmodule
